// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I instruction fields into 32-bit words.
// The immediate is range-checked per format. Illegal bundles are consumed and
// dropped, and they set a sticky error flag. Legal words are emitted over a
// valid/ready handshake, each tagged with its sequential byte address.
module instr_encoder #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   fmt,
  input  logic [6:0]                   opcode,
  input  logic [4:0]                   rd,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic [31:0]                  imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [31:0]                  out_instr,
  output logic                         full,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  // Format codes match the ImmSrc encoding of the main decoder.
  typedef enum logic [2:0] {
    FMT_I = 3'b000,
    FMT_U = 3'b001,
    FMT_S = 3'b010,
    FMT_B = 3'b011,
    FMT_J = 3'b100,
    FMT_R = 3'b111
  } fmt_e;

  fmt_e                  fmt_sel;
  logic                  fits12, fits13, fits21;
  logic [31:0]           word;
  logic                  legal;
  logic                  accept;
  logic                  full_w;

  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [CW-1:0]         count_q,     count_d;
  logic                  err_q,       err_d;

  assign fmt_sel = fmt_e'(fmt);

  // A value fits in N signed bits when every bit above bit N-1 repeats the sign.
  assign fits12 = (imm[31:11] == {21{imm[11]}});
  assign fits13 = (imm[31:12] == {20{imm[12]}});
  assign fits21 = (imm[31:20] == {12{imm[20]}});

  assign full_w   = (count_q == CW'(DEPTH));
  assign in_ready = !rst && !clr && !full_w && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Pack the word for the selected format and decide whether the bundle is legal.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned. An unassigned path would infer a latch.
    word  = '0;
    legal = 1'b0;
    case (fmt_sel)
      FMT_R: begin
        word  = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        word  = {imm[11:0], rs1, funct3, rd, opcode};
        legal = fits12;
      end
      FMT_S: begin
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = fits12;
      end
      FMT_B: begin
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        legal = fits13 && !imm[0];
      end
      FMT_U: begin
        word  = {imm[31:12], rd, opcode};
        legal = 1'b1;
      end
      FMT_J: begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = fits21 && !imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Next state: drain the output, load an accepted legal word, flag illegal ones.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_instr_d = out_instr_q;
    count_d     = count_q;
    err_d       = err_q;
    if (clr) begin
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_instr_d = '0;
      count_d     = '0;
      err_d       = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (legal) begin
          out_valid_d = 1'b1;
          out_addr_d  = ADDR_WIDTH'({count_q, 2'b00});
          out_instr_d = word;
          count_d     = count_q + CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its input from before the clock edge.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_instr_q <= out_instr_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_instr = out_instr_q;
  assign count     = count_q;
  assign full      = full_w;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder with DEPTH=4.
// Each expected word and address is pushed when its bundle is driven. The
// words are popped and compared when the output handshake completes.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam logic [2:0] F_I = 3'b000, F_U = 3'b001, F_S = 3'b010,
                         F_B = 3'b011, F_J = 3'b100, F_R = 3'b111;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic        in_ready, out_valid, full, err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_addr, out_instr;
  logic [2:0]  count;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .full(full), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop and compare each word at the negedge before its output handshake.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && out_ready) begin
      check("word_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_addr", out_addr, mon_e.addr);
        check("out_instr", out_instr, mon_e.instr);
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input bit legal,
                      input logic [31:0] ea, input logic [31:0] ei);
    int n = 0;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(in_ready), 32'd1);
    if (legal) sb.push_back({ea, ei});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_addr"}, out_addr, 32'd0);
    check({tag, "_out_instr"}, out_instr, 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b1;
    #1;
    check({tag, "_in_ready_during_clr"}, 32'(in_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_reset(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    check("in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);

    // I/S/U formats with the output always ready.
    send(F_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'd0, 32'h0050_0093);
    send(F_S, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'd4, 32'h0020_A423);
    send(F_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5ABC, 1'b1, 32'd8, 32'h1234_52B7);
    wait_drain("isu");
    check("isu_count", 32'(count), 32'd3);
    do_clr("clr1");

    // B/J formats, then illegal bundles and a resumption at the un-advanced address.
    send(F_B, 7'h63, 5'd31, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'd0, 32'hFE00_0EE3);
    send(F_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'd4, 32'h0080_00EF);
    send(F_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, 32'd0);
    check("ill_j_out_valid", 32'(out_valid), 32'd0);
    check("ill_j_err", 32'(err), 32'd1);
    check("ill_j_count", 32'(count), 32'd2);
    send(3'b101, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    check("ill_fmt_out_valid", 32'(out_valid), 32'd0);
    check("ill_fmt_count", 32'(count), 32'd2);
    send(F_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, 32'd0);
    check("ill_i_out_valid", 32'(out_valid), 32'd0);
    check("ill_i_count", 32'(count), 32'd2);
    send(F_B, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'd0, 32'd0);
    check("ill_b_count", 32'(count), 32'd2);
    send(F_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b1, 32'd8, 32'h8000_0093);
    send(F_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 1'b1, 32'd12, 32'h0020_81B3);
    wait_drain("ill");
    check("ill_err_sticky", 32'(err), 32'd1);
    check("ill_count", 32'(count), 32'd4);
    check("ill_full", 32'(full), 32'd1);
    do_clr("clr2");

    // Backpressure: the first word holds while the second bundle waits.
    out_ready = 1'b0;
    send(F_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'd0, 32'h0050_0093);
    fmt = F_I; opcode = 7'h13; rd = 5'd2; rs1 = 5'd0; funct3 = 3'd0; imm = 32'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_addr_hold", out_addr, 32'd0);
      check("bp_instr_hold", out_instr, 32'h0050_0093);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    sb.push_back({32'd4, 32'h0070_0113});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_addr", out_addr, 32'd4);
    wait_drain("bp");
    do_clr("clr3");

    // Fill to DEPTH. A fifth bundle is never accepted until clr.
    for (int n = 1; n <= 4; n++) begin
      send(F_I, 7'h13, 5'(n), 5'd0, 5'd0, 3'd0, 7'd0, 32'(n), 1'b1,
           32'((n - 1) * 4), (32'(n) << 20) | (32'(n) << 7) | 32'h13);
    end
    check("full_after_4", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd4);
    fmt = F_I; opcode = 7'h13; rd = 5'd5; rs1 = 5'd0; imm = 32'd5; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_count_held", 32'(count), 32'd4);
    wait_drain("full");
    do_clr("clr4");
    send(F_I, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'd0, 32'h0050_0293);
    wait_drain("after_clr");

    // Reset in the middle of backpressure discards the pending word.
    out_ready = 1'b0;
    send(F_I, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b1, 32'd4, 32'h0060_0313);
    check("rst_bp_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check_reset("rst_bp");
    rst = 1'b0;
    out_ready = 1'b1;
    send(F_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b1, 32'd0, 32'h0070_0113);
    wait_drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
